coder_scheduler: RTL and testbench

CODER_SCHEDULER -- requirements
Module: coder_scheduler

---
 rtl/coder_scheduler.sv | 146 ++++++++++++++
 tb/tb_coder_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/coder_scheduler.sv
// coder_scheduler
//   Shares a single external coder between two 12-bit request channels (A and B).
//   A granted word is driven to the coder, coder_en is held for SETTLE_CYCLES
//   cycles, and then the 24-bit coder output is captured and presented on a
//   result handshake tagged with the originating channel.
//
// Ports
//   clk        : single clock, rising-edge active
//   rst_n      : asynchronous active-low reset
//   a_valid/a_data/a_ready : channel A request handshake (a_ready is a combinational grant)
//   b_valid/b_data/b_ready : channel B request handshake (b_ready is a combinational grant)
//   coder_in   : word presented to the shared coder
//   coder_en   : coder enable, high while the coder is settling
//   coder_out  : coder result
//   out_valid/out_data/out_ch/out_ready : result handshake (out_ch 0=A, 1=B)
//   busy       : high whenever the scheduler is not idle
module coder_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    input  logic [11:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [11:0] b_data,
    output logic        b_ready,
    output logic [11:0] coder_in,
    output logic        coder_en,
    input  logic [23:0] coder_out,
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        out_ch,
    input  logic        out_ready,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    // last_grant_r: 1'b0 = A was granted last, 1'b1 = B was granted last
    logic [1:0]  state_r;
    logic [3:0]  cnt_r;
    logic        last_grant_r;
    logic [11:0] coder_in_r;
    logic        coder_en_r;
    logic        out_valid_r;
    logic [23:0] out_data_r;
    logic        out_ch_r;
    logic        busy_r;

    logic        grant_a_s;
    logic        grant_b_s;

    // Round-robin grant, only offered while idle; on a tie the channel not granted last wins
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (a_valid && b_valid) begin
                if (last_grant_r) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end else if (a_valid) begin
                grant_a_s = 1'b1;
            end else if (b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Scheduler FSM: accept a request, let the coder settle, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= 1'b1;
            coder_in_r   <= 12'd0;
            coder_en_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 24'd0;
            out_ch_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        coder_in_r   <= grant_b_s ? b_data : a_data;
                        out_ch_r     <= grant_b_s;
                        last_grant_r <= grant_b_s;
                        cnt_r        <= SETTLE_LD;
                        coder_en_r   <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    // Last settle cycle: coder output is valid on this edge
                    if (cnt_r == 4'd1) begin
                        out_data_r  <= coder_out;
                        out_valid_r <= 1'b1;
                        coder_en_r  <= 1'b0;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle without emitting a result
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    coder_en_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign a_ready   = grant_a_s;
    assign b_ready   = grant_b_s;
    assign coder_in  = coder_in_r;
    assign coder_en  = coder_en_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_coder_scheduler.sv
module tb_coder_scheduler;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [11:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [11:0] b_data;
    logic        b_ready;
    logic [11:0] coder_in;
    logic        coder_en;
    logic [23:0] coder_out;
    logic        out_valid;
    logic [23:0] out_data;
    logic        out_ch;
    logic        out_ready;
    logic        busy;

    logic        stub_mode;
    logic [23:0] stub_val;

    int checks;
    int failures;

    coder_scheduler #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .coder_in(coder_in), .coder_en(coder_en), .coder_out(coder_out),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready), .busy(busy)
    );

    // Coder stub: duplicates its input unless the bench overrides it
    assign coder_out = stub_mode ? stub_val : {coder_in, coder_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 12'd0; b_data = 12'd0;
        out_ready = 1'b0; stub_mode = 1'b0; stub_val = 24'd0;
        step(); step();
        checks++;
        if ({coder_en, out_valid, out_ch, busy, a_ready, b_ready} !== 6'b000000 ||
            coder_in !== 12'd0 || out_data !== 24'd0) begin
            failures++;
            $display("FAIL reset_state: en=%b ov=%b ch=%b busy=%b ar=%b br=%b cin=%h od=%h, required all zero",
                     coder_en, out_valid, out_ch, busy, a_ready, b_ready, coder_in, out_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_a_and_hold();
        a_valid = 1'b1; a_data = 12'h0F0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: ar=%b br=%b, required ar=1 br=0", a_ready, b_ready);
        end
        step();  // transfer edge T
        a_valid = 1'b0; a_data = 12'h000;
        checks++;
        if (coder_en !== 1'b1 || busy !== 1'b1 || coder_in !== 12'h0F0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_transfer: en=%b busy=%b cin=%h ov=%b, required en=1 busy=1 cin=0f0 ov=0",
                     coder_en, busy, coder_in, out_valid);
        end
        step();  // T+1
        checks++;
        if (coder_en !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL settle_t1: en=%b ov=%b, required en=1 ov=0", coder_en, out_valid);
        end
        step();  // T+2
        checks++;
        if (out_valid !== 1'b1 || out_data !== 24'h0F00F0 || out_ch !== 1'b0 || coder_en !== 1'b0) begin
            failures++;
            $display("FAIL result_t2: ov=%b od=%h ch=%b en=%b, required ov=1 od=0f00f0 ch=0 en=0",
                     out_valid, out_data, out_ch, coder_en);
        end
        // Hold with back-pressure while both channels request
        a_valid = 1'b1; b_valid = 1'b1; a_data = 12'h111; b_data = 12'h222;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 24'h0F00F0 || out_ch !== 1'b0 ||
                a_ready !== 1'b0 || b_ready !== 1'b0 || coder_in !== 12'h0F0) begin
                failures++;
                $display("FAIL hold_stable[%0d]: ov=%b od=%h ch=%b ar=%b br=%b cin=%h, required ov=1 od=0f00f0 ch=0 ar=0 br=0 cin=0f0",
                         i, out_valid, out_data, out_ch, a_ready, b_ready, coder_in);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        // Back in idle; A was granted last so the tie now goes to B
        if (out_valid !== 1'b0 || busy !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: ov=%b busy=%b ar=%b br=%b, required ov=0 busy=0 ar=0 br=1",
                     out_valid, busy, a_ready, b_ready);
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || coder_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_release: busy=%b en=%b, required 0 0", busy, coder_en);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        int last_i;
        logic exp_ch;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        a_valid = 1'b1; b_valid = 1'b1; a_data = 12'h123; b_data = 12'h456; out_ready = 1'b1;
        seen = 0; last_i = -1; exp_ch = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (out_valid === 1'b1) begin
                checks++;
                if (out_ch !== exp_ch || out_data !== (exp_ch ? 24'h456456 : 24'h123123) ||
                    (last_i >= 0 && (i - last_i) != 4)) begin
                    failures++;
                    $display("FAIL rr_result[%0d]: ch=%b od=%h spacing=%0d, required ch=%b od=%h spacing=4",
                             seen, out_ch, out_data, i - last_i, exp_ch,
                             exp_ch ? 24'h456456 : 24'h123123);
                end
                last_i = i;
                exp_ch = ~exp_ch;
                seen++;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (seen != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d results, required 4", seen);
        end
        step();
    endtask

    task automatic test_reset_in_wait();
        bit done;
        a_valid = 1'b1; a_data = 12'h0AB;
        step();  // transfer of A
        a_valid = 1'b0;
        step();  // mid-WAIT
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (coder_en !== 1'b0 || coder_in !== 12'd0 || out_valid !== 1'b0 || out_ch !== 1'b0 ||
            out_data !== 24'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: en=%b cin=%h ov=%b ch=%b od=%h busy=%b, required all zero",
                     coder_en, coder_in, out_valid, out_ch, out_data, busy);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || coder_en !== 1'b0) begin
                failures++;
                $display("FAIL no_result_after_reset[%0d]: ov=%b en=%b, required 0 0", i, out_valid, coder_en);
            end
        end
        a_valid = 1'b1; b_valid = 1'b1; a_data = 12'h3C3; b_data = 12'h5A5;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL tie_after_reset: ar=%b br=%b, required ar=1 br=0", a_ready, b_ready);
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (out_valid === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || out_ch !== 1'b0 || out_data !== 24'h3C33C3) begin
            failures++;
            $display("FAIL post_reset_result: seen=%b ch=%b od=%h, required seen=1 ch=0 od=3c33c3",
                     done, out_ch, out_data);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_only_b();
        b_valid = 1'b1; b_data = 12'hFFF;
        #1;
        checks++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL only_b_grant: ar=%b br=%b, required ar=0 br=1", a_ready, b_ready);
        end
        step();
        b_valid = 1'b0;
        stub_mode = 1'b1; stub_val = 24'hA5C3E1;
        checks++;
        if (coder_in !== 12'hFFF || coder_en !== 1'b1) begin
            failures++;
            $display("FAIL only_b_drive: cin=%h en=%b, required cin=fff en=1", coder_in, coder_en);
        end
        step(); step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 1'b1 || out_data !== 24'hA5C3E1) begin
            failures++;
            $display("FAIL only_b_result: ov=%b ch=%b od=%h, required ov=1 ch=1 od=a5c3e1",
                     out_valid, out_ch, out_data);
        end
        stub_mode = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL only_b_release: ov=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_out_ready_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || coder_en !== 1'b0) begin
                failures++;
                $display("FAIL ready_in_idle[%0d]: ov=%b busy=%b en=%b, required 0 0 0",
                         i, out_valid, busy, coder_en);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_a_and_hold();
        test_back_to_back();
        test_reset_in_wait();
        test_only_b();
        test_out_ready_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
